id_stage_pipe: RTL

//  Registered decode stage: IF_ID -> [id_stage_pipe] -> ID_EX; successor to the combinational decoder.

---
 rtl/id_stage_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : Registered MIPS decode stage (logic/shift/HI-LO/imm-logic subset)
//            with RegFile read, EX/MEM bypass, hazard stall and valid/ready out.
// Config   : define ID_FORWARD_EN to enable EX/MEM operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int WORD_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int EX_OP_WIDTH     = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_inst,
    input  logic                       i_flush,
    output logic [REG_ADDR_WIDTH-1:0]  o_readAddrLeft,
    output logic [REG_ADDR_WIDTH-1:0]  o_readAddrRight,
    output logic                       o_readEnableLeft,
    output logic                       o_readEnableRight,
    input  logic [WORD_WIDTH-1:0]      i_readValueLeft,
    input  logic [WORD_WIDTH-1:0]      i_readValueRight,
    input  logic                       i_exWriteEnable,
    input  logic [REG_ADDR_WIDTH-1:0]  i_exDest,
    input  logic [WORD_WIDTH-1:0]      i_exValue,
    input  logic                       i_exIsLoad,
    input  logic                       i_memWriteEnable,
    input  logic [REG_ADDR_WIDTH-1:0]  i_memDest,
    input  logic [WORD_WIDTH-1:0]      i_memValue,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_pc,
    output logic [EX_OP_WIDTH-1:0]     o_exop,
    output logic [REG_ADDR_WIDTH-1:0]  o_dest,
    output logic [WORD_WIDTH-1:0]      o_srcLeft,
    output logic [WORD_WIDTH-1:0]      o_srcRight,
    output logic [STALL_CNT_WIDTH-1:0] o_stallCount
);

    // Op code = {class[2:0], operation[4:0]}, zero-extended to EX_OP_WIDTH.
    localparam logic [7:0] c_OP_NOP  = {3'd0, 5'd0};
    localparam logic [7:0] c_OP_AND  = {3'd1, 5'd1};
    localparam logic [7:0] c_OP_OR   = {3'd1, 5'd2};
    localparam logic [7:0] c_OP_XOR  = {3'd1, 5'd3};
    localparam logic [7:0] c_OP_NOR  = {3'd1, 5'd4};
    localparam logic [7:0] c_OP_LUI  = {3'd1, 5'd5};
    localparam logic [7:0] c_OP_SLL  = {3'd2, 5'd1};
    localparam logic [7:0] c_OP_SRL  = {3'd2, 5'd2};
    localparam logic [7:0] c_OP_SRA  = {3'd2, 5'd3};
    localparam logic [7:0] c_OP_MFHI = {3'd3, 5'd1};
    localparam logic [7:0] c_OP_MFLO = {3'd3, 5'd2};
    localparam logic [7:0] c_OP_MTHI = {3'd3, 5'd3};
    localparam logic [7:0] c_OP_MTLO = {3'd3, 5'd4};
    localparam logic [REG_ADDR_WIDTH-1:0] c_REG_ZERO = '0;

    logic [5:0]                w_opcode;
    logic [5:0]                w_funct;
    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [REG_ADDR_WIDTH-1:0] w_rt;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [WORD_WIDTH-1:0]     w_shamt;
    logic [WORD_WIDTH-1:0]     w_imm;

    assign w_opcode = i_inst[31:26];
    assign w_funct  = i_inst[5:0];
    assign w_rs     = REG_ADDR_WIDTH'(i_inst[25:21]);
    assign w_rt     = REG_ADDR_WIDTH'(i_inst[20:16]);
    assign w_rd     = REG_ADDR_WIDTH'(i_inst[15:11]);
    assign w_shamt  = WORD_WIDTH'(i_inst[10:6]);
    assign w_imm    = WORD_WIDTH'(i_inst[15:0]);

    logic [7:0]                w_op;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic                      w_enL;
    logic                      w_enR;
    logic [WORD_WIDTH-1:0]     w_immL;
    logic [WORD_WIDTH-1:0]     w_immR;

    always_comb begin
        w_op   = c_OP_NOP;
        w_dest = c_REG_ZERO;
        w_enL  = 1'b0;
        w_enR  = 1'b0;
        w_immL = '0;
        w_immR = '0;
        case (w_opcode)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03: begin
                        w_enR  = 1'b1;
                        w_immL = w_shamt;
                        w_dest = w_rd;
                        w_op   = (w_funct == 6'h00) ? c_OP_SLL :
                                 (w_funct == 6'h02) ? c_OP_SRL : c_OP_SRA;
                    end
                    6'h04, 6'h06, 6'h07: begin
                        w_enL  = 1'b1;
                        w_enR  = 1'b1;
                        w_dest = w_rd;
                        w_op   = (w_funct == 6'h04) ? c_OP_SLL :
                                 (w_funct == 6'h06) ? c_OP_SRL : c_OP_SRA;
                    end
                    6'h10, 6'h12: begin
                        w_dest = w_rd;
                        w_op   = (w_funct == 6'h10) ? c_OP_MFHI : c_OP_MFLO;
                    end
                    6'h11, 6'h13: begin
                        w_enL = 1'b1;
                        w_op  = (w_funct == 6'h11) ? c_OP_MTHI : c_OP_MTLO;
                    end
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        w_enL  = 1'b1;
                        w_enR  = 1'b1;
                        w_dest = w_rd;
                        w_op   = (w_funct == 6'h24) ? c_OP_AND :
                                 (w_funct == 6'h25) ? c_OP_OR  :
                                 (w_funct == 6'h26) ? c_OP_XOR : c_OP_NOR;
                    end
                    default: ;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_enL  = 1'b1;
                w_immR = w_imm;
                w_dest = w_rt;
                w_op   = (w_opcode == 6'h0C) ? c_OP_AND :
                         (w_opcode == 6'h0D) ? c_OP_OR  :
                         (w_opcode == 6'h0E) ? c_OP_XOR : c_OP_LUI;
            end
            default: ;
        endcase
    end

    logic                  w_hazL;
    logic                  w_hazR;
    logic [WORD_WIDTH-1:0] w_valL;
    logic [WORD_WIDTH-1:0] w_valR;

`ifdef ID_FORWARD_EN
    logic w_exL, w_exR, w_memL, w_memR;

    assign w_exL  = i_exWriteEnable  && (i_exDest  == w_rs) && (w_rs != c_REG_ZERO);
    assign w_exR  = i_exWriteEnable  && (i_exDest  == w_rt) && (w_rt != c_REG_ZERO);
    assign w_memL = i_memWriteEnable && (i_memDest == w_rs) && (w_rs != c_REG_ZERO);
    assign w_memR = i_memWriteEnable && (i_memDest == w_rt) && (w_rt != c_REG_ZERO);

    // A load in EX has no result yet, so it can neither be bypassed nor skipped.
    assign w_hazL = w_enL && w_exL && i_exIsLoad;
    assign w_hazR = w_enR && w_exR && i_exIsLoad;
    assign w_valL = (w_exL && !i_exIsLoad) ? i_exValue :
                    w_memL                 ? i_memValue : i_readValueLeft;
    assign w_valR = (w_exR && !i_exIsLoad) ? i_exValue :
                    w_memR                 ? i_memValue : i_readValueRight;
`else
    logic w_unused;

    assign w_unused = ^{i_exValue, i_memValue, i_exIsLoad};
    assign w_hazL = w_enL && (w_rs != c_REG_ZERO) &&
                    ((i_exWriteEnable && (i_exDest == w_rs)) ||
                     (i_memWriteEnable && (i_memDest == w_rs)));
    assign w_hazR = w_enR && (w_rt != c_REG_ZERO) &&
                    ((i_exWriteEnable && (i_exDest == w_rt)) ||
                     (i_memWriteEnable && (i_memDest == w_rt)));
    assign w_valL = i_readValueLeft;
    assign w_valR = i_readValueRight;
`endif

    logic w_hazard;
    logic w_out_free;
    logic w_take;

    assign w_hazard   = w_hazL || w_hazR;
    assign w_out_free = !o_valid || i_ready;
    assign w_take     = i_valid && !w_hazard;
    assign o_ready    = i_flush || (w_out_free && !w_hazard);

    assign o_readAddrLeft    = w_rs;
    assign o_readAddrRight   = w_rt;
    assign o_readEnableLeft  = w_enL;
    assign o_readEnableRight = w_enR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_exop       <= EX_OP_WIDTH'(c_OP_NOP);
            o_dest       <= c_REG_ZERO;
            o_srcLeft    <= '0;
            o_srcRight   <= '0;
            o_stallCount <= '0;
        end else begin
            if (i_valid && w_hazard && !i_flush && (o_stallCount != '1)) begin
                o_stallCount <= o_stallCount + 1'b1;
            end
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (w_out_free) begin
                o_valid <= w_take;
                if (w_take) begin
                    o_pc       <= i_pc;
                    o_exop     <= EX_OP_WIDTH'(w_op);
                    o_dest     <= w_dest;
                    o_srcLeft  <= w_enL ? w_valL : w_immL;
                    o_srcRight <= w_enR ? w_valR : w_immR;
                end
            end
        end
    end

endmodule
`default_nettype wire
